// File: rtl/scan_sequencer.sv
// ---------------------------------------------------------------------------
// scan_sequencer
//
// Steps a downstream 2:4 decoder through the enabled channels of a 4-bit
// mask. Each channel is held for dwell+1 cycles. A pass is one visit to
// every enabled channel. In single-shot mode the block stops after one pass
// and pulses done. In free-run mode it repeats passes and pulses wrap on the
// first cycle of each new pass.
//
// Ports
//   clk    : clock; all state changes on its rising edge
//   rst    : synchronous active-high reset
//   start  : scan request; accepted only in IDLE, with stop=0 and mask!=0
//   stop   : abort; takes priority over start and over channel advance
//   mode   : 0 = single-shot, 1 = free-run (latched when start is accepted)
//   mask   : channel-enable set, bit i = channel i (latched at start)
//   dwell  : each channel is held for dwell+1 cycles (latched at start)
//   D      : registered channel select code for the decoder
//   En     : registered decoder enable, high while scanning
//   busy   : high while scanning (same as En)
//   done   : 1-cycle pulse when a single-shot pass ends
//   wrap   : 1-cycle pulse on the first cycle of each repeated free-run pass
// ---------------------------------------------------------------------------
module scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [3:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [1:0]         D,
  output logic               En,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t             state_q;
  logic [1:0]         d_q;
  logic               done_q;
  logic               wrap_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               mode_q;
  logic [3:0]         mask_q;

  logic [1:0]         firstCh_d;
  logic [1:0]         nextCh_d;
  logic               passEnd_d;
  logic [1:0]         idx;

  // Channel search. firstCh_d is the lowest set bit of the live mask input,
  // used when a start is accepted. nextCh_d is the next set bit of the
  // latched mask, searching upward from d_q+1 and wrapping modulo 4. The
  // loops run downward so the nearest candidate is assigned last and wins.
  // When only one mask bit is set, the search ends on d_q itself at offset 4.
  // A pass ends whenever the search does not move strictly upward.
  always_comb begin
    firstCh_d = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) firstCh_d = 2'(i);
    end

    nextCh_d = d_q;
    idx      = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      idx = d_q + 2'(i);
      if (mask_q[idx]) nextCh_d = idx;
    end

    passEnd_d = (nextCh_d <= d_q);
  end

  // Sequencer state machine. Reset has priority over everything. done and
  // wrap default low so that each is a single-cycle pulse. The dwell counter
  // reaching zero marks the last cycle on the current channel. Stop leaves D
  // where it was and raises no pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      d_q     <= 2'd0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
      dwell_q <= '0;
      mode_q  <= 1'b0;
      mask_q  <= 4'd0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !stop && (mask != 4'd0)) begin
            mode_q  <= mode;
            mask_q  <= mask;
            dwell_q <= dwell;
            d_q     <= firstCh_d;
            cnt_q   <= dwell;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (stop) begin
            state_q <= IDLE;
          end else if (cnt_q == '0) begin
            cnt_q <= dwell_q;
            if (passEnd_d && !mode_q) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              d_q    <= nextCh_d;
              wrap_q <= passEnd_d;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign D    = d_q;
  assign En   = (state_q == SCAN);
  assign busy = (state_q == SCAN);
  assign done = done_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_scan_sequencer
//
// Self-checking bench for scan_sequencer. The reference model works at the
// pass level. When a scan is accepted, or a free-run pass repeats, the model
// fills a queue with the channel codes the pass must present: each enabled
// channel, in ascending order, repeated dwell+1 times. The first entry of a
// repeated pass is tagged with wrap. Each clock edge consumes one entry. An
// empty queue ends the scan in single-shot mode or refills it in free-run
// mode. Directed scenarios come first, followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_scan_sequencer;

  localparam int DWELL_W = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               stop;
  logic               mode;
  logic [3:0]         mask;
  logic [DWELL_W-1:0] dwell;
  logic [1:0]         D;
  logic               En;
  logic               busy;
  logic               done;
  logic               wrap;

  scan_sequencer #(.DWELL_W(DWELL_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .mode  (mode),
    .mask  (mask),
    .dwell (dwell),
    .D     (D),
    .En    (En),
    .busy  (busy),
    .done  (done),
    .wrap  (wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ch;
    logic       wrap;
  } slot_t;

  slot_t      slots[$];
  bit         mActive = 0;
  bit         mDone   = 0;
  bit         mDKnown = 0;
  logic [1:0] mLastD  = 2'd0;
  bit         mMode   = 0;
  logic [3:0] mMask   = 4'd0;
  int         mDwell  = 0;

  int nChecks = 0;
  int nPassed = 0;
  int cycle   = 0;
  int doneCnt = 0;

  // Counts one comparison and reports it if it does not match.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    nChecks++;
    if (observed == expected) begin
      nPassed++;
    end else begin
      $display("[TB] FAIL %s: observed %0d expected %0d (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  // Fills the queue with one full pass over the latched mask.
  function automatic void buildPass(input bit markWrap);
    bit first = 1;
    slot_t s;
    for (int ch = 0; ch < 4; ch++) begin
      if (mMask[ch]) begin
        for (int k = 0; k <= mDwell; k++) begin
          s.ch   = 2'(ch);
          s.wrap = markWrap && first;
          first  = 0;
          slots.push_back(s);
        end
      end
    end
  endfunction

  // Advances the model across one clock edge using the sampled inputs.
  function automatic void modelEdge(input bit r, input bit s, input bit p,
                                    input bit m, input logic [3:0] mk, input int dw);
    mDone = 0;
    if (r) begin
      slots.delete();
      mActive = 0;
      mLastD  = 2'd0;
      mDKnown = 1;
      mMode   = 0;
      mMask   = 4'd0;
      mDwell  = 0;
    end else if (mActive) begin
      if (p) begin
        slots.delete();
        mActive = 0;
        mDKnown = 0;
      end else begin
        mLastD = slots[0].ch;
        void'(slots.pop_front());
        if (slots.size() == 0) begin
          if (!mMode) begin
            mActive = 0;
            mDone   = 1;
          end else begin
            buildPass(1);
          end
        end
      end
    end else if (s && !p && (mk != 4'd0)) begin
      mMode   = m;
      mMask   = mk;
      mDwell  = dw;
      buildPass(0);
      mActive = 1;
      mDKnown = 1;
    end
  endfunction

  // Drives one cycle of inputs at the falling edge, lets the rising edge
  // sample them, then compares every output with the model.
  task automatic applyStimulus(input bit r, input bit s, input bit p,
                               input bit m, input logic [3:0] mk, input int dw);
    @(negedge clk);
    rst   = r;
    start = s;
    stop  = p;
    mode  = m;
    mask  = mk;
    dwell = DWELL_W'(dw);
    @(posedge clk);
    #1;
    cycle++;
    modelEdge(r, s, p, m, mk, dw);
    if (done) doneCnt++;
    checkOutput("En",   int'(En),   int'(mActive));
    checkOutput("busy", int'(busy), int'(mActive));
    checkOutput("done", int'(done), int'(mDone));
    checkOutput("wrap", int'(wrap), mActive ? int'(slots[0].wrap) : 0);
    if (mActive)      checkOutput("D", int'(D), int'(slots[0].ch));
    else if (mDKnown) checkOutput("D_hold", int'(D), int'(mLastD));
  endtask

  // Idle cycles with start and stop low and noise on the latched inputs.
  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 0, 0, 1'($urandom), 4'($urandom), int'($urandom_range(0, 7)));
    end
  endtask

  initial begin
    rst = 1; start = 0; stop = 0; mode = 0; mask = 4'd0; dwell = '0;

    applyStimulus(1, 0, 0, 0, 4'd0, 0);
    applyStimulus(1, 0, 0, 0, 4'd0, 0);

    // Single-shot over all four channels, dwell 2.
    applyStimulus(0, 1, 0, 0, 4'b1111, 2);
    idleCycles(14);

    // Sparse mask with dwell 0.
    doneCnt = 0;
    applyStimulus(0, 1, 0, 0, 4'b1010, 0);
    idleCycles(4);
    checkOutput("sparse_done_count", doneCnt, 1);

    // Free-run over channels 0 and 2, then stop.
    doneCnt = 0;
    applyStimulus(0, 1, 0, 1, 4'b0101, 1);
    idleCycles(11);
    applyStimulus(0, 0, 1, 0, 4'd0, 0);
    idleCycles(2);
    checkOutput("freerun_no_done", doneCnt, 0);

    // Stop on the third scan cycle.
    applyStimulus(0, 1, 0, 0, 4'b1111, 5);
    idleCycles(2);
    applyStimulus(0, 0, 1, 0, 4'b1111, 5);
    idleCycles(2);

    // Start with an empty mask, and start together with stop, are both ignored.
    applyStimulus(0, 1, 0, 0, 4'd0, 3);
    idleCycles(1);
    applyStimulus(0, 1, 1, 0, 4'b1111, 3);
    idleCycles(1);

    // Reset mid-scan while D=2, with start held during reset.
    applyStimulus(0, 1, 0, 1, 4'b1111, 0);
    idleCycles(2);
    checkOutput("pre_reset_D", int'(D), 2);
    applyStimulus(1, 1, 0, 1, 4'b1111, 0);
    applyStimulus(0, 1, 0, 0, 4'b0110, 1);
    idleCycles(6);

    // Randomized traffic, including starts and input changes during a scan.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 39) == 0),
                    1'($urandom),
                    4'($urandom),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                : int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
